// File: rtl/time_counter.sv
// rtl/time_counter.sv - 24 h HH:MM BCD real-time keeper with validated time load
// Counts one_second strobes into minutes and advances four BCD digits; rejects out-of-range loads.
module time_counter #(
    parameter int SECONDS_PER_MIN = 60
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       one_second,
    input  logic       load_new_c,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_min,
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min,
    output logic       load_error,
    output logic       minute_tick
);

    localparam int SEC_W = (SECONDS_PER_MIN > 1) ? $clog2(SECONDS_PER_MIN) : 1;
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SECONDS_PER_MIN - 1);

    logic [SEC_W-1:0] sec_count;
    logic             load_valid;
    logic             min_adv;
    logic [3:0]       next_ms_hr;
    logic [3:0]       next_ls_hr;
    logic [3:0]       next_ms_min;
    logic [3:0]       next_ls_min;

    always_comb begin
        load_valid = (new_current_time_ms_hr <= 4'd2)
                  && (new_current_time_ls_hr <= 4'd9)
                  && ((new_current_time_ms_hr != 4'd2) || (new_current_time_ls_hr <= 4'd3))
                  && (new_current_time_ms_min <= 4'd5)
                  && (new_current_time_ls_min <= 4'd9);
    end

    assign min_adv = one_second && (sec_count == SEC_LAST);

    // Time of day one minute ahead, with BCD carries and the 23:59 -> 00:00 wrap
    always_comb begin
        next_ms_hr  = current_time_ms_hr;
        next_ls_hr  = current_time_ls_hr;
        next_ms_min = current_time_ms_min;
        next_ls_min = current_time_ls_min;
        if (current_time_ls_min != 4'd9) begin
            next_ls_min = current_time_ls_min + 4'd1;
        end else begin
            next_ls_min = 4'd0;
            if (current_time_ms_min != 4'd5) begin
                next_ms_min = current_time_ms_min + 4'd1;
            end else begin
                next_ms_min = 4'd0;
                if ((current_time_ms_hr == 4'd2) && (current_time_ls_hr == 4'd3)) begin
                    next_ms_hr = 4'd0;
                    next_ls_hr = 4'd0;
                end else if (current_time_ls_hr == 4'd9) begin
                    next_ls_hr = 4'd0;
                    next_ms_hr = current_time_ms_hr + 4'd1;
                end else begin
                    next_ls_hr = current_time_ls_hr + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sec_count           <= '0;
            current_time_ms_hr  <= 4'd0;
            current_time_ls_hr  <= 4'd0;
            current_time_ms_min <= 4'd0;
            current_time_ls_min <= 4'd0;
            load_error          <= 1'b0;
            minute_tick         <= 1'b0;
        end else if (load_new_c && load_valid) begin
            // A valid load discards any coincident strobe and restarts the minute
            sec_count           <= '0;
            current_time_ms_hr  <= new_current_time_ms_hr;
            current_time_ls_hr  <= new_current_time_ls_hr;
            current_time_ms_min <= new_current_time_ms_min;
            current_time_ls_min <= new_current_time_ls_min;
            load_error          <= 1'b0;
            minute_tick         <= 1'b0;
        end else begin
            load_error  <= load_new_c;
            minute_tick <= min_adv;
            if (min_adv) begin
                sec_count           <= '0;
                current_time_ms_hr  <= next_ms_hr;
                current_time_ls_hr  <= next_ls_hr;
                current_time_ms_min <= next_ms_min;
                current_time_ls_min <= next_ls_min;
            end else if (one_second) begin
                sec_count <= sec_count + SEC_W'(1);
            end
        end
    end

endmodule
